// File: rtl/gate_delay_meter.sv
// gate_delay_meter
//   Measures the delay, in clk cycles, from a transition on stim to the
//   matching transition on resp. Each delay is classified as a rise
//   (resp went 0->1) or a fall (resp went 1->0). Running min/max/count
//   statistics are kept separately for rises and falls.
//
// Parameters
//   CNT_W   : width of the delay counter and of all delay/stat outputs
//   TIMEOUT : cycles to wait for a response (1 .. 2^CNT_W-1)
//
// Ports
//   clk, rst            : clock (rising edge), async active-high reset
//   stim, resp          : stimulus and observed response (clk-synchronous)
//   clr_stats           : synchronous clear of the statistics
//   meas_valid          : 1-cycle pulse, measurement complete
//   meas_rise           : 1 = rise delay, 0 = fall delay (with meas_valid)
//   meas_delay          : measured delay in cycles (with meas_valid)
//   timeout             : 1-cycle pulse, no response within TIMEOUT cycles
//   overrun             : 1-cycle pulse, new stim edge while measuring
//   spurious            : 1-cycle pulse, resp edge with nothing pending
//   rise_min/max, fall_min/max : running delay statistics
//   rise_cnt, fall_cnt  : measurement counts, saturating at 16'hFFFF
module gate_delay_meter #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stim,
   input  logic             resp,
   input  logic             clr_stats,
   output logic             meas_valid,
   output logic             meas_rise,
   output logic [CNT_W-1:0] meas_delay,
   output logic             timeout,
   output logic             overrun,
   output logic             spurious,
   output logic [CNT_W-1:0] rise_min,
   output logic [CNT_W-1:0] rise_max,
   output logic [CNT_W-1:0] fall_min,
   output logic [CNT_W-1:0] fall_max,
   output logic [15:0]      rise_cnt,
   output logic [15:0]      fall_cnt
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_MEAS = 1'b1;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   logic             stim_q, resp_q;
   logic             primed_reg;
   logic             state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   logic             stim_edge, resp_edge;
   logic             rep_next, ovr_next, tmo_next, spur_next;
   logic [CNT_W-1:0] rep_delay_next;

   assign stim_edge = stim ^ stim_q;
   assign resp_edge = resp ^ resp_q;

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      rep_next       = 1'b0;
      rep_delay_next = '0;
      ovr_next       = 1'b0;
      tmo_next       = 1'b0;
      spur_next      = 1'b0;
      // Until the first post-reset edge has loaded the sample registers,
      // the edge detectors compare against reset values, not real history.
      if (primed_reg) begin
         case (state_reg)
            ST_IDLE: begin
               if (stim_edge && resp_edge) begin
                  rep_next = 1'b1;
               end else if (stim_edge) begin
                  state_next = ST_MEAS;
                  cnt_next   = CNT_W'(1);
               end else if (resp_edge) begin
                  spur_next = 1'b1;
               end
            end
            default: begin
               if (resp_edge) begin
                  rep_next       = 1'b1;
                  rep_delay_next = cnt_reg;
                  // A simultaneous stim edge immediately opens the next window.
                  if (stim_edge) begin
                     cnt_next = CNT_W'(1);
                  end else begin
                     state_next = ST_IDLE;
                     cnt_next   = '0;
                  end
               end else if (stim_edge) begin
                  ovr_next = 1'b1;
                  cnt_next = CNT_W'(1);
               end else if (cnt_reg == TIMEOUT_C) begin
                  tmo_next   = 1'b1;
                  state_next = ST_IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stim_q     <= 1'b0;
         resp_q     <= 1'b0;
         primed_reg <= 1'b0;
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         meas_valid <= 1'b0;
         meas_rise  <= 1'b0;
         meas_delay <= '0;
         timeout    <= 1'b0;
         overrun    <= 1'b0;
         spurious   <= 1'b0;
      end else begin
         stim_q     <= stim;
         resp_q     <= resp;
         primed_reg <= 1'b1;
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         meas_valid <= rep_next;
         timeout    <= tmo_next;
         overrun    <= ovr_next;
         spurious   <= spur_next;
         if (rep_next) begin
            meas_rise  <= resp;
            meas_delay <= rep_delay_next;
         end
      end
   end

   // Statistics: set 1 tracks rises (new resp level 1), set 0 tracks falls.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_stat
         logic [CNT_W-1:0] min_reg, max_reg;
         logic [15:0]      num_reg;
         logic             hit;

         assign hit = rep_next && (resp == (gi == 1));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               min_reg <= '1;
               max_reg <= '0;
               num_reg <= '0;
            end else if (clr_stats) begin
               // Clear takes precedence over a sample landing this cycle.
               min_reg <= '1;
               max_reg <= '0;
               num_reg <= '0;
            end else if (hit) begin
               if (rep_delay_next < min_reg) min_reg <= rep_delay_next;
               if (rep_delay_next > max_reg) max_reg <= rep_delay_next;
               if (num_reg != 16'hFFFF) num_reg <= num_reg + 16'd1;
            end
         end
      end
   endgenerate

   assign rise_min = g_stat[1].min_reg;
   assign rise_max = g_stat[1].max_reg;
   assign rise_cnt = g_stat[1].num_reg;
   assign fall_min = g_stat[0].min_reg;
   assign fall_max = g_stat[0].max_reg;
   assign fall_cnt = g_stat[0].num_reg;

endmodule
